// File: rtl/ward_call_arbiter.sv
// ward_call_arbiter: latches bed calls as pending and grants one at a time.
// The selection policy is chosen at run time, and an alarm escalates an unacknowledged grant.
module ward_call_arbiter #(
    parameter int N = 8,
    parameter int TIMEOUT = 15,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [1:0]       mode,
    input  logic             ack,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             alarm
);
    typedef enum logic {IDLE, SERVE} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t state, state_n;
    logic [N-1:0] pending_n, clr;
    logic [IDX_W-1:0] gnt_n, rr_ptr, rr_n, hi, lo, rr_sel, pick;
    logic [7:0] timer, timer_n;
    logic alarm_n;

    assign gnt_valid = state == SERVE;
    assign pend_cnt = CNT_W'($countones(pending));

    // Later loop passes overwrite earlier ones, so each scan runs away from its preferred end.
    always_comb begin
        hi = '0;
        lo = '0;
        rr_sel = '0;
        for (int i = 0; i < N; i++)
            if (pending[IDX_W'(i)]) hi = IDX_W'(i);
        for (int i = N - 1; i >= 0; i--)
            if (pending[IDX_W'(i)]) lo = IDX_W'(i);
        for (int k = N; k >= 1; k--)
            if (pending[IDX_W'((int'(rr_ptr) + k) % N)]) rr_sel = IDX_W'((int'(rr_ptr) + k) % N);
        pick = mode == 2'b01 ? lo : mode == 2'b10 ? rr_sel : hi;
    end

    always_comb begin
        state_n = state;
        gnt_n = gnt_idx;
        alarm_n = alarm;
        timer_n = timer;
        rr_n = rr_ptr;
        clr = (state == SERVE && ack) ? N'(1) << gnt_idx : '0;
        pending_n = (pending & ~clr) | req;
        if (state == IDLE) begin
            if (|pending) begin
                state_n = SERVE;
                gnt_n = pick;
                timer_n = '0;
            end
        end else if (ack) begin
            state_n = IDLE;
            gnt_n = '0;
            alarm_n = 1'b0;
            timer_n = '0;
            rr_n = gnt_idx;
        end else begin
            // The timer saturates at TO, so the alarm test below equals timer+1 >= TO.
            timer_n = timer < TO ? timer + 8'd1 : timer;
            alarm_n = alarm | (timer_n >= TO);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            gnt_idx <= '0;
            alarm <= 1'b0;
            timer <= '0;
            rr_ptr <= IDX_W'(N - 1);
        end else begin
            state <= state_n;
            pending <= pending_n;
            gnt_idx <= gnt_n;
            alarm <= alarm_n;
            timer <= timer_n;
            rr_ptr <= rr_n;
        end
    end
endmodule

// File: tb/tb_ward_call_arbiter.sv
// tb_ward_call_arbiter: directed and random stimulus checked against a
// behavioural model of pending calls, grant order and the escalation alarm.
module tb_ward_call_arbiter;
    localparam int N = 8;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [1:0] mode = 2'b00;
    logic ack = 1'b0;
    logic gnt_valid, alarm;
    logic [2:0] gnt_idx;
    logic [N-1:0] pending;
    logic [3:0] pend_cnt;

    int total = 0;
    int bad = 0;

    logic [N-1:0] m_pend;
    bit m_srv;
    int m_gnt, m_last, m_wait;
    int order[$];
    bit prev_valid;

    ward_call_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode), .ack(ack),
        .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .pending(pending),
        .pend_cnt(pend_cnt), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sel(input logic [N-1:0] p, input logic [1:0] m, input int last);
        if (m == 2'b01) begin
            for (int i = 0; i < N; i++) if (p[i]) return i;
        end else if (m == 2'b10) begin
            for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
        end else begin
            for (int i = N - 1; i >= 0; i--) if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [1:0] m, input logic a, input logic rs);
        logic [N-1:0] np;
        @(negedge clk);
        req = r;
        mode = m;
        ack = a;
        rst = rs;
        @(posedge clk);
        if (rs) begin
            m_pend = '0; m_srv = 0; m_gnt = 0; m_last = N - 1; m_wait = 0;
        end else begin
            np = (m_pend & ~((m_srv && a) ? (N'(1) << m_gnt) : N'(0))) | r;
            if (m_srv) begin
                if (a) begin
                    m_srv = 0; m_last = m_gnt; m_gnt = 0; m_wait = 0;
                end else m_wait = (m_wait + 1 > TO) ? TO : m_wait + 1;
            end else if (m_pend != 0) begin
                m_srv = 1; m_gnt = sel(m_pend, m, m_last); m_wait = 0;
            end
            m_pend = np;
        end
        #1;
        chk("gnt_valid", gnt_valid, m_srv);
        chk("gnt_idx", gnt_idx, m_gnt);
        chk("pending", pending, m_pend);
        chk("pend_cnt", pend_cnt, $countones(m_pend));
        chk("alarm", alarm, m_srv && m_wait >= TO);
    endtask

    initial begin
        step('0, 0, 0, 1);
        step('0, 0, 0, 1);
        chk("reset_valid", gnt_valid, 0);
        chk("reset_ptr_free", pending, 0);
        // highest-index-first
        step(8'h24, 0, 0, 0);
        step('0, 0, 0, 0);
        chk("hi_first", gnt_idx, 5);
        step('0, 0, 1, 0);
        chk("hi_after_ack", pending, 8'h04);
        step('0, 0, 0, 0);
        chk("hi_second", gnt_idx, 2);
        step('0, 0, 1, 0);
        // lowest-index-first
        step(8'h24, 1, 0, 0);
        chk("lo_cnt2", pend_cnt, 2);
        step('0, 1, 0, 0);
        chk("lo_first", gnt_idx, 2);
        step('0, 1, 1, 0);
        chk("lo_cnt1", pend_cnt, 1);
        step('0, 1, 0, 0);
        chk("lo_second", gnt_idx, 5);
        step('0, 1, 1, 0);
        chk("lo_cnt0", pend_cnt, 0);
        // round-robin over all beds, then wrap
        step('0, 0, 0, 1);
        step(8'hff, 2, 0, 0);
        prev_valid = 0;
        for (int c = 0; c < 20; c++) begin
            step('0, 2, m_srv, 0);
            if (gnt_valid && !prev_valid) order.push_back(int'(gnt_idx));
            prev_valid = gnt_valid;
        end
        chk("rr_count", order.size(), 8);
        foreach (order[i]) chk("rr_order", order[i], i);
        step(8'h01, 2, 0, 0);
        step('0, 2, 0, 0);
        chk("rr_wrap", gnt_idx, 0);
        step('0, 2, 1, 0);
        step(8'h08, 2, 0, 0);
        step('0, 2, 0, 0);
        step('0, 2, 1, 0);
        step(8'h08, 2, 0, 0);
        step('0, 2, 0, 0);
        chk("rr_sole", gnt_idx, 3);
        step('0, 2, 1, 0);
        // alarm timing
        step(8'h01, 0, 0, 0);
        step('0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            step('0, 0, 0, 0);
            chk("alarm_timing", alarm, i >= TO);
        end
        step('0, 0, 1, 0);
        chk("alarm_clear", alarm, 0);
        // re-pend on ack, mode changes frozen
        step(8'h10, 0, 0, 0);
        step('0, 0, 0, 0);
        step('0, 1, 0, 0);
        step('0, 2, 0, 0);
        chk("mode_frozen", gnt_idx, 4);
        step(8'h10, 0, 1, 0);
        chk("repend", pending[4], 1);
        step('0, 0, 0, 0);
        chk("regrant", gnt_idx, 4);
        // full load with simultaneous req
        step(8'hff, 0, 0, 0);
        step(8'hff, 0, 0, 0);
        chk("full_cnt", pend_cnt, 8);
        // reset mid-SERVE with alarm high
        for (int i = 0; i < TO + 2; i++) step('0, 0, 0, 0);
        chk("pre_rst_alarm", alarm, 1);
        step('0, 0, 0, 1);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_alarm", alarm, 0);
        step(8'h24, 2, 0, 0);
        step('0, 2, 0, 0);
        chk("rr_after_rst", gnt_idx, 2);
        // random traffic
        for (int c = 0; c < 3000; c++)
            step(($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0), 2'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
